// File: rtl/row_scan_pkg.sv
// Shared types, limits and the field clamp for the row scan sequencer.
package row_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Shortest en-high dwell that still lets the decoder's registered row output settle.
    localparam int unsigned MIN_PULSE = 2;
    localparam int unsigned MIN_GAP   = 1;

    function automatic int unsigned clamp(input int unsigned value,
                                          input int unsigned lo,
                                          input int unsigned hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/row_scan_ctrl_dwell_timer.sv
// Loadable down-counter timing one dwell phase (en-high pulse or en-low gap).
module dwell_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] value,
    output logic          last,
    output logic          next_last
);

    logic [TW-1:0] r_cnt;

    // Loading `value` makes the next cycle the first counted one; `last` marks the value-th.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign last      = (r_cnt == TW'(1));
    assign next_last = (r_cnt == TW'(2));

endmodule

// File: rtl/row_scan_ctrl.sv
// Row-by-row scan sequencer driving the paired-row decoder's en/row_sel,
// with a sample strobe for the column sense stage and a done/aborted report.
module row_scan_ctrl #(
    parameter int unsigned PAIR_ROW_NO = 64,
    parameter int unsigned TW          = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [$clog2(PAIR_ROW_NO)-1:0] req_row_start,
    input  logic [$clog2(PAIR_ROW_NO):0]   req_row_cnt,
    input  logic [TW-1:0]                  req_pulse_cyc,
    input  logic [TW-1:0]                  req_gap_cyc,
    input  logic                           abort,
    output logic                           en,
    output logic [$clog2(PAIR_ROW_NO)-1:0] row_sel,
    output logic                           sample,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted
);

    import row_scan_pkg::*;

    localparam int unsigned ROW_W = $clog2(PAIR_ROW_NO);
    localparam int unsigned CNT_W = ROW_W + 1;
    localparam int unsigned T_MAX = (1 << TW) - 1;

    state_t             r_state;
    logic [ROW_W-1:0]   r_row_sel;
    logic [CNT_W-1:0]   r_rows_left;
    logic [TW-1:0]      r_pulse;
    logic [TW-1:0]      r_gap;
    logic               r_aborted;
    logic               r_en;
    logic               r_sample;
    logic               r_busy;
    logic               r_done;
    logic               r_req_ready;

    state_t             w_state_nxt;
    logic [ROW_W-1:0]   w_row_sel_nxt;
    logic [CNT_W-1:0]   w_rows_left_nxt;
    logic [TW-1:0]      w_pulse_nxt;
    logic [TW-1:0]      w_gap_nxt;
    logic               w_aborted_nxt;
    logic               w_sample_nxt;
    logic               w_tmr_load;
    logic [TW-1:0]      w_tmr_value;
    logic               w_tmr_last;
    logic               w_tmr_next_last;

    logic [TW-1:0]      w_req_pulse;
    logic [TW-1:0]      w_req_gap;
    logic [CNT_W-1:0]   w_req_rows;
    logic [CNT_W-1:0]   w_rows_dec;
    logic [ROW_W-1:0]   w_row_inc;

    // Request fields clamped to the legal dwell and row-count ranges.
    assign w_req_pulse = TW'(clamp(32'(req_pulse_cyc), MIN_PULSE, T_MAX));
    assign w_req_gap   = TW'(clamp(32'(req_gap_cyc), MIN_GAP, T_MAX));
    assign w_req_rows  = CNT_W'(clamp(32'(req_row_cnt), 0, PAIR_ROW_NO));

    assign w_rows_dec  = r_rows_left - CNT_W'(1);
    assign w_row_inc   = (r_row_sel == ROW_W'(PAIR_ROW_NO - 1)) ? '0 : r_row_sel + ROW_W'(1);

    dwell_timer #(
        .TW (TW)
    ) u_dwell_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_tmr_load),
        .value     (w_tmr_value),
        .last      (w_tmr_last),
        .next_last (w_tmr_next_last)
    );

    // Next-state and datapath updates; abort takes priority over the dwell timer.
    always_comb begin
        w_state_nxt     = r_state;
        w_row_sel_nxt   = r_row_sel;
        w_rows_left_nxt = r_rows_left;
        w_pulse_nxt     = r_pulse;
        w_gap_nxt       = r_gap;
        w_aborted_nxt   = r_aborted;
        w_sample_nxt    = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_value     = r_pulse;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_pulse_nxt     = w_req_pulse;
                    w_gap_nxt       = w_req_gap;
                    w_rows_left_nxt = w_req_rows;
                    w_row_sel_nxt   = req_row_start;
                    w_aborted_nxt   = 1'b0;
                    if (w_req_rows == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = PULSE;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = w_req_pulse;
                    end
                end
            end

            PULSE: begin
                if (abort) begin
                    w_state_nxt   = DONE;
                    w_aborted_nxt = 1'b1;
                end else begin
                    // Strobe lands on the final pulse cycle since the output is registered.
                    w_sample_nxt = w_tmr_next_last;
                    if (w_tmr_last) begin
                        w_rows_left_nxt = w_rows_dec;
                        if (w_rows_dec != '0) begin
                            w_state_nxt = GAP;
                            w_tmr_load  = 1'b1;
                            w_tmr_value = r_gap;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    w_state_nxt   = DONE;
                    w_aborted_nxt = 1'b1;
                end else if (w_tmr_last) begin
                    w_row_sel_nxt = w_row_inc;
                    w_state_nxt   = PULSE;
                    w_tmr_load    = 1'b1;
                    w_tmr_value   = r_pulse;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs derive from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row_sel   <= '0;
            r_rows_left <= '0;
            r_pulse     <= '0;
            r_gap       <= '0;
            r_aborted   <= 1'b0;
            r_en        <= 1'b0;
            r_sample    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_row_sel   <= w_row_sel_nxt;
            r_rows_left <= w_rows_left_nxt;
            r_pulse     <= w_pulse_nxt;
            r_gap       <= w_gap_nxt;
            r_aborted   <= w_aborted_nxt;
            r_en        <= (w_state_nxt == PULSE);
            r_sample    <= w_sample_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == DONE);
            r_req_ready <= (w_state_nxt == IDLE);
        end
    end

    assign req_ready = r_req_ready;
    assign en        = r_en;
    assign row_sel   = r_row_sel;
    assign sample    = r_sample;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Self-checking bench for row_scan_ctrl: directed table, reset sequence and
// randomized scans compared cycle by cycle against a trace model.
`timescale 1ns/1ps
module tb_row_scan_ctrl;

    localparam int unsigned PAIR_ROW_NO = 64;
    localparam int unsigned TW          = 8;
    localparam int unsigned ROW_W       = $clog2(PAIR_ROW_NO);

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [ROW_W-1:0] req_row_start;
    logic [ROW_W:0]   req_row_cnt;
    logic [TW-1:0]    req_pulse_cyc;
    logic [TW-1:0]    req_gap_cyc;
    logic             abort;
    logic             en;
    logic [ROW_W-1:0] row_sel;
    logic             sample;
    logic             busy;
    logic             done;
    logic             aborted;

    row_scan_ctrl #(
        .PAIR_ROW_NO (PAIR_ROW_NO),
        .TW          (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_row_start (req_row_start),
        .req_row_cnt   (req_row_cnt),
        .req_pulse_cyc (req_pulse_cyc),
        .req_gap_cyc   (req_gap_cyc),
        .abort         (abort),
        .en            (en),
        .row_sel       (row_sel),
        .sample        (sample),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int row;
        bit sample;
        bit done;
    } cyc_t;

    typedef struct {
        int start;
        int cnt;
        int pulse;
        int gap;
        int abort_at;
        int exp_busy;
        int exp_samples;
        int exp_aborted;
    } vec_t;

    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int scan_len(input int cnt, input int pulse, input int gap);
        int p, g, n;
        p = (pulse < 2) ? 2 : pulse;
        g = (gap < 1) ? 1 : gap;
        n = (cnt > PAIR_ROW_NO) ? PAIR_ROW_NO : cnt;
        return (n == 0) ? 1 : n * p + (n - 1) * g + 1;
    endfunction

    // Expected per-cycle trace after accept; returns whether the scan ends aborted.
    function automatic bit build_model(input int start, input int cnt, input int pulse,
                                       input int gap, input int abort_at);
        int   p, g, n;
        bit   ab;
        cyc_t c;
        p = (pulse < 2) ? 2 : pulse;
        g = (gap < 1) ? 1 : gap;
        n = (cnt > PAIR_ROW_NO) ? PAIR_ROW_NO : cnt;
        exp_q.delete();
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < p; i++) begin
                c.en = 1'b1; c.row = (start + r) % PAIR_ROW_NO;
                c.sample = (i == p - 1); c.done = 1'b0;
                exp_q.push_back(c);
            end
            if (r < n - 1) begin
                for (int i = 0; i < g; i++) begin
                    c.en = 1'b0; c.row = 0; c.sample = 1'b0; c.done = 1'b0;
                    exp_q.push_back(c);
                end
            end
        end
        ab = (abort_at > 0) && (abort_at <= exp_q.size());
        if (ab) begin
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
        end
        c.en = 1'b0; c.row = 0; c.sample = 1'b0; c.done = 1'b1;
        exp_q.push_back(c);
        return ab;
    endfunction

    task automatic drive_req(input int start, input int cnt, input int pulse, input int gap);
        req_row_start = ROW_W'(start);
        req_row_cnt   = (ROW_W + 1)'(cnt);
        req_pulse_cyc = TW'(pulse);
        req_gap_cyc   = TW'(gap);
        req_valid     = 1'b1;
    endtask

    // Called right after the accept edge has been set up; walks cycles 1..L+1.
    task automatic check_trace(input int start, input int cnt, input int pulse, input int gap,
                               input int abort_at, input string tag,
                               output int busy_n, output int samp_n);
        bit   ab;
        int   len;
        cyc_t e;
        ab = build_model(start, cnt, pulse, gap, abort_at);
        len = exp_q.size();
        busy_n = 0;
        samp_n = 0;
        for (int k = 1; k <= len; k++) begin
            e = exp_q[k-1];
            @(negedge clk);
            chk($sformatf("%s en c%0d", tag, k), int'(en), int'(e.en));
            if (e.en) chk($sformatf("%s row_sel c%0d", tag, k), int'(row_sel), e.row);
            chk($sformatf("%s sample c%0d", tag, k), int'(sample), int'(e.sample));
            chk($sformatf("%s done c%0d", tag, k), int'(done), int'(e.done));
            chk($sformatf("%s busy c%0d", tag, k), int'(busy), 1);
            chk($sformatf("%s req_ready c%0d", tag, k), int'(req_ready), 0);
            chk($sformatf("%s aborted c%0d", tag, k), int'(aborted), (k == len) ? int'(ab) : 0);
            busy_n += int'(busy);
            samp_n += int'(sample);
            if (k == len) begin
                req_valid = 1'b0;
                abort     = 1'($urandom_range(0, 1));
            end else begin
                abort         = (k == abort_at);
                req_valid     = 1'($urandom_range(0, 1));
                req_row_start = ROW_W'($urandom_range(0, PAIR_ROW_NO - 1));
                req_row_cnt   = (ROW_W + 1)'($urandom_range(0, 5));
                req_pulse_cyc = TW'($urandom_range(0, 7));
                req_gap_cyc   = TW'($urandom_range(0, 7));
            end
        end
        @(negedge clk);
        abort = 1'b0;
        chk($sformatf("%s idle busy", tag), int'(busy), 0);
        chk($sformatf("%s idle req_ready", tag), int'(req_ready), 1);
        chk($sformatf("%s idle en", tag), int'(en), 0);
        chk($sformatf("%s idle done", tag), int'(done), 0);
        chk($sformatf("%s idle sample", tag), int'(sample), 0);
        chk($sformatf("%s idle aborted", tag), int'(aborted), int'(ab));
        busy_n += int'(busy);
    endtask

    task automatic run_scan(input int start, input int cnt, input int pulse, input int gap,
                            input int abort_at, input string tag,
                            output int busy_n, output int samp_n);
        chk($sformatf("%s pre req_ready", tag), int'(req_ready), 1);
        drive_req(start, cnt, pulse, gap);
        check_trace(start, cnt, pulse, gap, abort_at, tag, busy_n, samp_n);
    endtask

    vec_t vecs[6];

    initial begin
        int busy_n, samp_n;
        int start, cnt, pulse, gap, len, abort_at;

        vecs[0] = '{start: 5,  cnt: 3,   pulse: 4, gap: 2, abort_at: 0,  exp_busy: 17,  exp_samples: 3,  exp_aborted: 0};
        vecs[1] = '{start: 62, cnt: 4,   pulse: 2, gap: 1, abort_at: 0,  exp_busy: 12,  exp_samples: 4,  exp_aborted: 0};
        vecs[2] = '{start: 0,  cnt: 100, pulse: 0, gap: 0, abort_at: 0,  exp_busy: 192, exp_samples: 64, exp_aborted: 0};
        vecs[3] = '{start: 9,  cnt: 0,   pulse: 7, gap: 3, abort_at: 0,  exp_busy: 1,   exp_samples: 0,  exp_aborted: 0};
        vecs[4] = '{start: 0,  cnt: 4,   pulse: 5, gap: 3, abort_at: 10, exp_busy: 11,  exp_samples: 1,  exp_aborted: 1};
        vecs[5] = '{start: 5,  cnt: 3,   pulse: 4, gap: 2, abort_at: 0,  exp_busy: 17,  exp_samples: 3,  exp_aborted: 0};

        rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
        req_row_start = '0; req_row_cnt = '0; req_pulse_cyc = '0; req_gap_cyc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset en", int'(en), 0);
        chk("reset row_sel", int'(row_sel), 0);
        chk("reset sample", int'(sample), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset aborted", int'(aborted), 0);
        chk("reset req_ready", int'(req_ready), 1);
        rst = 1'b0;

        // Abort while idle must have no effect.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle abort busy", int'(busy), 0);
        chk("idle abort aborted", int'(aborted), 0);

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].start, vecs[i].cnt, vecs[i].pulse, vecs[i].gap, vecs[i].abort_at,
                     $sformatf("vec%0d", i), busy_n, samp_n);
            chk($sformatf("vec%0d busy_cycles", i), busy_n, vecs[i].exp_busy);
            chk($sformatf("vec%0d samples", i), samp_n, vecs[i].exp_samples);
            chk($sformatf("vec%0d aborted_final", i), int'(aborted), vecs[i].exp_aborted);
        end

        // Reset mid-PULSE with req_valid held high throughout.
        chk("rstseq pre req_ready", int'(req_ready), 1);
        drive_req(10, 3, 6, 2);
        @(negedge clk);
        chk("rstseq c1 en", int'(en), 1);
        chk("rstseq c1 row_sel", int'(row_sel), 10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstseq en", int'(en), 0);
        chk("rstseq row_sel", int'(row_sel), 0);
        chk("rstseq sample", int'(sample), 0);
        chk("rstseq busy", int'(busy), 0);
        chk("rstseq done", int'(done), 0);
        chk("rstseq aborted", int'(aborted), 0);
        chk("rstseq req_ready", int'(req_ready), 1);
        rst = 1'b0;
        drive_req(20, 2, 3, 1);
        check_trace(20, 2, 3, 1, 0, "rstseq", busy_n, samp_n);
        chk("rstseq busy_cycles", busy_n, 8);
        chk("rstseq samples", samp_n, 2);

        for (int i = 0; i < 40; i++) begin
            start = int'($urandom_range(0, PAIR_ROW_NO - 1));
            cnt   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 100))
                                                 : int'($urandom_range(0, 6));
            pulse = int'($urandom_range(0, 6));
            gap   = int'($urandom_range(0, 4));
            len   = scan_len(cnt, pulse, gap);
            abort_at = (len > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                abort = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk($sformatf("rnd%0d gap busy", i), int'(busy), 0);
            end
            abort = 1'b0;
            run_scan(start, cnt, pulse, gap, abort_at, $sformatf("rnd%0d", i), busy_n, samp_n);
            chk($sformatf("rnd%0d busy_cycles", i), busy_n,
                (abort_at > 0) ? abort_at + 1 : len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/row_scan_ctrl.md
Name: row_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the paired-row decoder in the crossbar array datapath.
- Accepts a scan request over a valid/ready handshake: start row, row count, pulse width, gap width.
- Drives the decoder's en/row_sel through a timed row-by-row scan.
- Emits a sample strobe for the column sense stage and a done pulse when the scan ends.

Parameters:
- PAIR_ROW_NO, 64, number of paired rows; row_sel width is $clog2(PAIR_ROW_NO).
- TW, 8, width of the pulse and gap cycle-count fields.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  scan request valid.
- req_ready  output  1  high only in IDLE.
- req_row_start  input  $clog2(PAIR_ROW_NO)  first row of the scan.
- req_row_cnt  input  $clog2(PAIR_ROW_NO)+1  rows to scan, 0..PAIR_ROW_NO.
- req_pulse_cyc  input  TW  en-high cycles per row.
- req_gap_cyc  input  TW  en-low cycles between rows.
- abort  input  1  terminate the scan early.
- en  output  1  decoder enable.
- row_sel  output  $clog2(PAIR_ROW_NO)  decoder row select.
- sample  output  1  one-cycle strobe: decoder row outputs are valid.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at end of scan.
- aborted  output  1  qualifies done: scan ended by abort; held until the next accept.

Behaviour:
- Outputs registered. Reset values: en=0, row_sel=0, sample=0, busy=0, done=0, aborted=0, state=IDLE, all counters 0.
- Reset mid-scan returns to these values on the next edge; no done pulse is generated.
- States: IDLE, PULSE, GAP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch all fields, clear aborted.
  - P = max(req_pulse_cyc, 2). The minimum of 2 lets the decoder's registered row output settle before sampling.
  - G = max(req_gap_cyc, 1).
  - N = min(req_row_cnt, PAIR_ROW_NO).
  - If N==0: go to DONE, with no en activity.
  - Otherwise go to PULSE, with row_sel=req_row_start and en=1 on the following cycle.
- PULSE:
  - en=1 for exactly P cycles; row_sel stable throughout.
  - sample=1 on the last (P-th) PULSE cycle only.
  - After the P-th cycle, decrement the remaining-row count.
  - If rows remain: go to GAP.
  - Else: go to DONE (no trailing gap).
- GAP:
  - en=0 for exactly G cycles; row_sel holds the previous row.
  - On the last GAP cycle, row_sel advances to row_sel+1, wrapping from PAIR_ROW_NO-1 to 0.
  - Then go to PULSE.
- DONE:
  - One cycle: done=1, en=0, busy=1.
  - Then go to IDLE.
- Abort:
  - Sampled in PULSE or GAP; abort has priority over the timer.
  - Next cycle: en=0, sample=0, state=DONE, aborted=1.
  - Ignored in IDLE and DONE.
- Latency, accept to first en=1: 1 cycle.
- Total busy cycles: N·P + (N-1)·G + 1 (DONE).
- Request fields are not re-sampled during a scan; req_valid is ignored while busy.

Decomposition:
- Package row_scan_pkg holds:
  - state enum (IDLE, PULSE, GAP, DONE);
  - constants MIN_PULSE=2 and MIN_GAP=1;
  - the clamp function.
- One natural sub-module, dwell_timer:
  - TW-bit loadable down-counter;
  - inputs load/value;
  - output `last` asserted on the final counted cycle;
  - reused for both PULSE and GAP.

Test Plan:
- Basic scan: start=5, cnt=3, pulse=4, gap=2 -> en high cycles 1–4, 7–10, 13–16 after accept; row_sel 5,6,7; sample at cycles 4, 10, 16; done at cycle 17; req_ready back at 18.
- Wrap: start=62, cnt=4, pulse=2, gap=1 (PAIR_ROW_NO=64) -> row_sel sequence 62,63,0,1; 4 sample strobes; no en glitch across the wrap.
- Clamps: pulse=0, gap=0, cnt=100 -> P=2, G=1, N=64; exactly 64 samples; busy for 64·2+63+1=192 cycles.
- cnt=0 -> en never asserts; done one cycle after accept; aborted=0.
- Abort asserted on the 2nd PULSE cycle of row 1 (start=0, cnt=4, pulse=5) -> en=0 the next cycle; no sample for row 1; done next; aborted=1; next request clears aborted.
- rst asserted mid-PULSE for 1 cycle -> all outputs 0 next edge; no done; req_valid held high throughout -> new scan accepted the cycle after rst deasserts.
